// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and mode constants.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SCK_HI = 3'd2,
        SCK_LO = 3'd3,
        GAP    = 3'd4
    } state_e;

    // Only mode 0 is implemented; kept here so other modes can be added later.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_phase_timer.sv
// Half-period counter for the SPI master: strobes phase_end_o on the last
// cycle of each CLK_DIV-long phase and wraps, so every state starts at count 0.
module spi_phase_timer
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic phase_end_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        phase_end_o = (cnt_q == CW'(CLK_DIV - 1));
        cnt_d       = cnt_q + 1'b1;
        if (clr_i || phase_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode 0 master: one start pulse runs a WIDTH-bit full-duplex transfer,
// MSB first, returning the received word with a one-cycle done pulse.
module spi_master
    import spi_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] p_out,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             cs,
    output logic             mosi,
    input  logic             miso
);

    localparam int BW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sclk_q, sclk_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic             phase_end;
    logic             last_bit;

    spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (state_q == IDLE),
        .phase_end_o (phase_end)
    );

    assign last_bit = (bit_q == BW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        p_out_d = p_out_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = p_in;
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    mosi_d  = p_in[WIDTH-1];
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    sclk_d  = ~CPOL;
                    shift_d = {shift_q[WIDTH-2:0], miso};
                    state_d = SCK_HI;
                end
            end
            SCK_HI: begin
                // After the shift, the MSB already holds the next bit to send.
                if (phase_end) begin
                    sclk_d = CPOL;
                    if (!last_bit) begin
                        mosi_d = shift_q[WIDTH-1];
                    end
                    state_d = SCK_LO;
                end
            end
            SCK_LO: begin
                if (phase_end) begin
                    if (last_bit) begin
                        cs_d    = 1'b1;
                        done_d  = 1'b1;
                        p_out_d = shift_q;
                        state_d = GAP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        sclk_d  = ~CPOL;
                        shift_d = {shift_q[WIDTH-2:0], miso};
                        state_d = SCK_HI;
                    end
                end
            end
            GAP: begin
                if (phase_end) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            p_out_q <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= CPOL;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            p_out_q <= p_out_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
        end
    end

    assign p_out = p_out_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sclk  = sclk_q;
    assign cs    = cs_q;
    assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: an 8-bit/CLK_DIV=2 instance with loopback or a
// mode 0 slave model, and a 16-bit/CLK_DIV=1 instance in loopback.
module tb_spi_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=8, CLK_DIV=2
    logic       start_a = 1'b0;
    logic [7:0] p_in_a = 8'h00;
    logic [7:0] p_out_a;
    logic       busy_a, done_a, sclk_a, cs_a, mosi_a, miso_a;
    logic       loop_a = 1'b1;

    // Instance B: WIDTH=16, CLK_DIV=1, loopback
    logic        start_b = 1'b0;
    logic [15:0] p_in_b = 16'h0000;
    logic [15:0] p_out_b;
    logic        busy_b, done_b, sclk_b, cs_b, mosi_b, miso_b;

    spi_master #(.WIDTH(8), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .p_in(p_in_a), .p_out(p_out_a),
        .busy(busy_a), .done(done_a), .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_master #(.WIDTH(16), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .p_in(p_in_b), .p_out(p_out_b),
        .busy(busy_b), .done(done_b), .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b), .miso(miso_b)
    );

    // Mode 0 slave model: bit index advances on each sclk fall, resets while cs high.
    logic [7:0] s_word = 8'h00;
    logic [7:0] s_rx = 8'h00;
    logic [7:0] s_cap = 8'h00;
    logic [2:0] s_idx = 3'd0;
    logic       mosi_last = 1'b0;
    int         mosi_bad = 0;
    int         done_cnt_a = 0;

    assign miso_a = loop_a ? mosi_a : s_word[~s_idx];
    assign miso_b = mosi_b;

    always @(negedge sclk_a or posedge cs_a) begin
        if (cs_a) s_idx <= 3'd0;
        else      s_idx <= s_idx + 3'd1;
    end

    always @(posedge sclk_a) begin
        if (!cs_a) begin
            s_rx <= {s_rx[6:0], mosi_a};
            if (mosi_a !== mosi_last) mosi_bad <= mosi_bad + 1;
        end
    end

    always @(posedge cs_a) s_cap <= s_rx;
    always @(negedge clk) mosi_last <= mosi_a;
    always @(posedge clk) if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Called at #1 after a clock edge with the DUT idle; cycle 0 is the accepting edge.
    task automatic xfer_a(input logic [7:0] din, input logic lb, input logic [7:0] sw,
                          output logic [7:0] dout, output int done_c, output int busy_c,
                          output int rises);
        logic prev_sclk;
        dout = 8'h00; done_c = -1; busy_c = -1; rises = 0; prev_sclk = 1'b0;
        loop_a = lb; s_word = sw; p_in_a = din; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; p_in_a = ~din;
        for (int c = 1; c < 200; c++) begin
            if (sclk_a && !prev_sclk) rises++;
            prev_sclk = sclk_a;
            if (done_a) begin done_c = c; dout = p_out_a; end
            if (!busy_a) begin busy_c = c; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic xfer_b(input logic [15:0] din, output logic [15:0] dout, output int done_c,
                          output int busy_c, output int rises, output int hi_cyc);
        logic prev_sclk;
        dout = 16'h0000; done_c = -1; busy_c = -1; rises = 0; hi_cyc = 0; prev_sclk = 1'b0;
        p_in_b = din; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0; p_in_b = ~din;
        for (int c = 1; c < 200; c++) begin
            if (sclk_b && !prev_sclk) rises++;
            if (sclk_b) hi_cyc++;
            prev_sclk = sclk_b;
            if (done_b) begin done_c = c; dout = p_out_b; end
            if (!busy_b) begin busy_c = c; break; end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [7:0] din;
        logic       lb;
        logic [7:0] sw;
        logic [7:0] exp_out;
        int         exp_done;
        int         exp_busy;
    } vec_t;

    vec_t vec[5];

    initial begin
        logic [7:0]  dout;
        logic [15:0] dout_b;
        int          dc, bc, r, hc, cs_hi, d0, nd, acc;
        logic        prev_busy;
        logic [7:0]  bb[3];
        logic [7:0]  got[3];

        vec[0] = '{8'hA5, 1'b1, 8'h00, 8'hA5, 35, 37};
        vec[1] = '{8'hA5, 1'b0, 8'h3C, 8'h3C, 35, 37};
        vec[2] = '{8'h00, 1'b1, 8'h00, 8'h00, 35, 37};
        vec[3] = '{8'hFF, 1'b0, 8'h00, 8'h00, 35, 37};
        vec[4] = '{8'h5A, 1'b0, 8'hC3, 8'hC3, 35, 37};
        bb[0] = 8'h01; bb[1] = 8'h80; bb[2] = 8'hFF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_a", cs_a, 1); chk("rst_sclk_a", sclk_a, 0); chk("rst_mosi_a", mosi_a, 0);
        chk("rst_busy_a", busy_a, 0); chk("rst_done_a", done_a, 0); chk("rst_pout_a", p_out_a, 0);
        chk("rst_cs_b", cs_b, 1); chk("rst_busy_b", busy_b, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            xfer_a(vec[i].din, vec[i].lb, vec[i].sw, dout, dc, bc, r);
            chk($sformatf("vec%0d_pout", i), dout, vec[i].exp_out);
            chk($sformatf("vec%0d_done_cyc", i), dc, vec[i].exp_done);
            chk($sformatf("vec%0d_busy_fall", i), bc, vec[i].exp_busy);
            chk($sformatf("vec%0d_rises", i), r, 8);
            if (!vec[i].lb) chk($sformatf("vec%0d_slave_rx", i), s_cap, vec[i].din);
        end
        chk("mosi_stable_at_rise", mosi_bad, 0);

        // Second start at cycle 10 lands while busy and must be dropped.
        d0 = done_cnt_a; loop_a = 1'b1; p_in_a = 8'h3C; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start_a = 1'b1; p_in_a = 8'hFF;
        @(posedge clk); #1;
        start_a = 1'b0;
        cs_hi = 0;
        for (int c = 0; c < 200 && busy_a; c++) begin
            @(posedge clk); #1;
            cs_hi = cs_a ? cs_hi + 1 : 0;
        end
        chk("ign_busy_fell", busy_a, 0);
        chk("ign_done_count", done_cnt_a - d0, 1);
        chk("ign_pout", p_out_a, 8'h3C);
        xfer_a(8'h96, 1'b1, 8'h00, dout, dc, bc, r);
        chk("ign_next_immediate", dc, 35);
        chk("ign_next_pout", dout, 8'h96);
        chk("ign_cs_gap_ge_div", cs_hi >= 2, 1);

        // Asynchronous reset in the middle of a transfer.
        d0 = done_cnt_a; loop_a = 1'b1; p_in_a = 8'hC3; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs", cs_a, 1); chk("mid_rst_sclk", sclk_a, 0);
        chk("mid_rst_busy", busy_a, 0); chk("mid_rst_pout", p_out_a, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt_a - d0, 0);
        xfer_a(8'h5A, 1'b1, 8'h00, dout, dc, bc, r);
        chk("post_rst_pout", dout, 8'h5A);
        chk("post_rst_done_cyc", dc, 35);

        // 16-bit, CLK_DIV=1 instance.
        xfer_b(16'h8001, dout_b, dc, bc, r, hc);
        chk("b_pout", dout_b, 16'h8001);
        chk("b_done_cyc", dc, 34);
        chk("b_busy_fall", bc, 35);
        chk("b_rises", r, 16);
        chk("b_sclk_hi_cycles", hc, 16);

        // start held high: three back-to-back transfers, p_in updated after each accept.
        loop_a = 1'b1; p_in_a = bb[0]; start_a = 1'b1;
        acc = 0; nd = 0; prev_busy = busy_a;
        got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
        for (int c = 0; c < 400 && nd < 3; c++) begin
            @(posedge clk); #1;
            if (busy_a && !prev_busy) begin
                acc++;
                if (acc < 3) p_in_a = bb[acc];
                else start_a = 1'b0;
            end
            prev_busy = busy_a;
            if (done_a) begin got[nd] = p_out_a; nd++; end
        end
        start_a = 1'b0;
        chk("b2b_done_count", nd, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("b2b_pout%0d", i), got[i], bb[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
